// File: rtl/fpu_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_sequencer
//
// Purpose:
//   Shares the byte-wide, memory-mapped FPU between two 32-bit requesters.
//   Requesters are served round-robin. For each granted command the block
//   writes operand A, operand B and the opcode into FPU registers 0x0-0x8.
//   The opcode write starts the FPU. The block then waits for cmd_end, reads
//   result bytes 0x9-0xC, acknowledges the FPU, and returns the 32-bit word
//   to the granted requester. If cmd_end never arrives, the command is aborted
//   after TIMEOUT cycles and an error response is returned.
//
// Ports:
//   clk, arst_n          clock, synchronous active-low reset
//   req_valid[1:0]       pending command per requester
//   reqN_a/_b/_op        operands and opcode of requester N
//   req_accept[1:0]      one-cycle pulse: command of requester i latched
//   rsp_valid[1:0]       one-cycle pulse: response for requester i
//   rsp_result, rsp_err  result word (held) and timeout flag
//   fpu_addr/wdata/rdata FPU register address and data
//   fpu_cs_n/wr_n/rd_n   FPU strobes, active-low
//   fpu_end_ack          acknowledge to FPU, fpu_cmd_end FPU done
//   busy                 high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module fpu_sequencer #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req1_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req0_op,
    input  logic [3:0]  req1_op,
    output logic [1:0]  req_accept,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_result,
    output logic        rsp_err,
    output logic [3:0]  fpu_addr,
    output logic [7:0]  fpu_wdata,
    input  logic [7:0]  fpu_rdata,
    output logic        fpu_cs_n,
    output logic        fpu_wr_n,
    output logic        fpu_rd_n,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_STB,
        WR_REC,
        WAIT_END,
        RD_STB,
        RD_REC,
        ACK,
        RESP
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            gnt_q, gnt_d;
    logic [3:0]      idx_q, idx_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [3:0]      op_q, op_d;
    logic [31:0]     res_q, res_d;
    logic            err_q, err_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            pick;
    logic [71:0]     wr_word;

    logic [1:0]      req_accept_q, req_accept_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic            rsp_err_q, rsp_err_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            cs_n_q, cs_n_d;
    logic            wr_n_q, wr_n_d;
    logic            rd_n_q, rd_n_d;
    logic            end_ack_q, end_ack_d;
    logic            busy_q, busy_d;

    // Round-robin choice: on a tie the requester that was not served last
    // wins; otherwise the single active requester wins.
    always_comb begin
        if (req_valid == 2'b11) begin
            pick = ~rr_q;
        end else begin
            pick = req_valid[1];
        end
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            idx_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 4'd0;
            res_q   <= 32'd0;
            err_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        err_d        = err_q;
        to_d         = to_q;
        req_accept_d = 2'b00;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    gnt_d        = pick;
                    rr_d         = pick;
                    a_d          = pick ? req1_a  : req0_a;
                    b_d          = pick ? req1_b  : req0_b;
                    op_d         = pick ? req1_op : req0_op;
                    idx_d        = 4'd0;
                    req_accept_d = pick ? 2'b10 : 2'b01;
                    state_d      = WR_STB;
                end
            end
            WR_STB: begin
                state_d = WR_REC;
            end
            WR_REC: begin
                if (idx_q == 4'd8) begin
                    to_d    = '0;
                    state_d = WAIT_END;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = WR_STB;
                end
            end
            WAIT_END: begin
                to_d = to_q + TO_W'(1);
                // cmd_end has priority over an expiring timeout.
                if (fpu_cmd_end) begin
                    idx_d   = 4'd0;
                    state_d = RD_STB;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    res_d   = 32'd0;
                    state_d = ACK;
                end
            end
            RD_STB: begin
                res_d[{idx_q[1:0], 3'b000} +: 8] = fpu_rdata;
                state_d = RD_REC;
            end
            RD_REC: begin
                if (idx_q == 4'd3) begin
                    err_d   = 1'b0;
                    state_d = ACK;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = RD_STB;
                end
            end
            ACK: begin
                // Hold the acknowledge until the FPU has dropped cmd_end,
                // which also drains a late cmd_end after a timeout.
                if (!fpu_cmd_end) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Byte image of the FPU register file 0x0-0x8, little-endian.
    assign wr_word = {4'h0, op_d, b_d, a_d};

    // Output values are derived from the upcoming state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        cs_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        rd_n_d       = 1'b1;
        end_ack_d    = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = 2'b00;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = (state_d != IDLE);

        case (state_d)
            WR_STB: begin
                addr_d  = idx_d;
                wdata_d = wr_word[{idx_d, 3'b000} +: 8];
                cs_n_d  = 1'b0;
                wr_n_d  = 1'b0;
            end
            RD_STB: begin
                addr_d = 4'd9 + idx_d;
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
            end
            ACK: begin
                end_ack_d = 1'b1;
            end
            RESP: begin
                rsp_valid_d  = gnt_d ? 2'b10 : 2'b01;
                rsp_result_d = res_d;
                rsp_err_d    = err_d;
            end
            default: begin
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            req_accept_q <= 2'b00;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= 32'd0;
            rsp_err_q    <= 1'b0;
            addr_q       <= 4'd0;
            wdata_q      <= 8'd0;
            cs_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            end_ack_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            req_accept_q <= req_accept_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cs_n_q       <= cs_n_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            end_ack_q    <= end_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign req_accept  = req_accept_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_err     = rsp_err_q;
    assign fpu_addr    = addr_q;
    assign fpu_wdata   = wdata_q;
    assign fpu_cs_n    = cs_n_q;
    assign fpu_wr_n    = wr_n_q;
    assign fpu_rd_n    = rd_n_q;
    assign fpu_end_ack = end_ack_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fpu_sequencer
//
// Bench for fpu_sequencer. A small FPU model answers the byte protocol and
// returns hand-computed results for a few directed operand sets. Expected
// accepts and responses are queued when stimulus is issued. A monitor pops
// them whenever the DUT pulses req_accept / rsp_valid, and checks the strobe
// protocol on every cycle.
// -----------------------------------------------------------------------------
module tb_fpu_sequencer;

    localparam int TIMEOUT = 64;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_MUL = 4'h3;

    // Directed vectors: 1.5 + 2.25 = 3.75, 2.0 * 3.0 = 6.0, 10.0 - 5.0 = 5.0
    localparam logic [31:0] V0_A = 32'h3FC00000, V0_B = 32'h40100000, V0_R = 32'h40700000;
    localparam logic [31:0] V1_A = 32'h40000000, V1_B = 32'h40400000, V1_R = 32'h40C00000;
    localparam logic [31:0] V2_A = 32'h41200000, V2_B = 32'h40A00000, V2_R = 32'h40A00000;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [1:0]  req_valid;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [1:0]  req_accept, rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic [3:0]  fpu_addr;
    logic [7:0]  fpu_wdata;
    logic [7:0]  fpu_rdata;
    logic        fpu_cs_n, fpu_wr_n, fpu_rd_n, fpu_end_ack;
    logic        fpu_cmd_end;
    logic        busy;

    always #5 clk = ~clk;

    fpu_sequencer #(
        .TIMEOUT(TIMEOUT),
        .TO_W(7)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .req_valid(req_valid),
        .req0_a(req0_a),
        .req1_a(req1_a),
        .req0_b(req0_b),
        .req1_b(req1_b),
        .req0_op(req0_op),
        .req1_op(req1_op),
        .req_accept(req_accept),
        .rsp_valid(rsp_valid),
        .rsp_result(rsp_result),
        .rsp_err(rsp_err),
        .fpu_addr(fpu_addr),
        .fpu_wdata(fpu_wdata),
        .fpu_rdata(fpu_rdata),
        .fpu_cs_n(fpu_cs_n),
        .fpu_wr_n(fpu_wr_n),
        .fpu_rd_n(fpu_rd_n),
        .fpu_end_ack(fpu_end_ack),
        .fpu_cmd_end(fpu_cmd_end),
        .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] result;
        logic        err;
        int          waitLen;
        int          ackLen;
        int          nReads;
    } rsp_t;

    rsp_t rspQ[$];
    int   acceptQ[$];
    int   checks = 0;
    int   errors = 0;
    int   acceptCount = 0;

    // FPU model configuration: cycles from opcode write to cmd_end (0 = never)
    // and number of end_ack cycles before cmd_end is released.
    int   endDelay = 5;
    int   ackHold  = 1;

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event within bound, expected one", name);
    endtask

    task automatic expectResponse(input int id, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [31:0] result, input logic err,
                                  input int waitLen, input int ackLen, input int nReads);
        rsp_t e;
        e.id = id; e.a = a; e.b = b; e.op = op; e.result = result; e.err = err;
        e.waitLen = waitLen; e.ackLen = ackLen; e.nReads = nReads;
        rspQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic [1:0] mask, input int n);
        int target = acceptCount + n;
        int budget = 0;
        req_valid = mask;
        while (acceptCount < target && budget < 200 * n) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 2'b00;
        if (acceptCount < target) failNow("accept_wait");
    endtask

    task automatic waitDone();
        int budget = 0;
        while ((rspQ.size() != 0 || busy) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 500) failNow("done_wait");
        @(negedge clk);
    endtask

    // FPU model: records register writes, computes from a lookup of the
    // directed vectors, serves result bytes and handles cmd_end / end_ack.
    logic [71:0] fpuRegs;
    logic [31:0] fpuResult;
    int          endCnt;
    bit          armed;
    int          ackSeen;

    function automatic logic [31:0] fpuCompute(input logic [71:0] regs);
        case (regs)
            {4'h0, OP_ADD, V0_B, V0_A}: return V0_R;
            {4'h0, OP_MUL, V1_B, V1_A}: return V1_R;
            {4'h0, OP_SUB, V2_B, V2_A}: return V2_R;
            default:                    return 32'hDEADBEEF;
        endcase
    endfunction

    initial begin
        fpu_cmd_end = 1'b0;
        fpu_rdata   = 8'h00;
        fpuRegs     = '0;
        fpuResult   = '0;
        endCnt      = 0;
        armed       = 1'b0;
        ackSeen     = 0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                fpu_cmd_end = 1'b0;
                armed       = 1'b0;
                ackSeen     = 0;
            end else begin
                if (!fpu_cs_n && !fpu_wr_n) begin
                    if (fpu_addr <= 4'd8) fpuRegs[int'(fpu_addr) * 8 +: 8] = fpu_wdata;
                    if (fpu_addr == 4'd8) begin
                        fpuResult = fpuCompute(fpuRegs);
                        if (endDelay > 0) begin
                            armed  = 1'b1;
                            endCnt = endDelay;
                        end
                    end
                end else if (armed) begin
                    endCnt--;
                    if (endCnt == 0) begin
                        fpu_cmd_end = 1'b1;
                        armed       = 1'b0;
                    end
                end
                if (!fpu_cs_n && !fpu_rd_n && fpu_addr >= 4'd9 && fpu_addr <= 4'd12)
                    fpu_rdata = fpuResult[(int'(fpu_addr) - 9) * 8 +: 8];
                if (fpu_cmd_end && fpu_end_ack) begin
                    ackSeen++;
                    if (ackSeen >= ackHold) begin
                        fpu_cmd_end = 1'b0;
                        ackSeen     = 0;
                    end
                end
            end
        end
    end

    // Monitor: per-transaction collection of the bus activity, strobe
    // protocol checks, and scoreboard compare on accept / response.
    logic [35:0] wrAddrs;
    logic [71:0] wrBytes;
    logic [15:0] rdAddrs;
    int          nWrites, nReads, waitPhase, waitCnt, ackCnt, expId;
    logic        prevStrobe, prevEndAck, anyLow;
    rsp_t        e;

    always @(negedge clk) begin
        if (!arst_n) begin
            prevStrobe = 1'b0;
            prevEndAck = 1'b0;
            waitPhase  = 0;
        end else begin
            anyLow = !fpu_cs_n || !fpu_wr_n || !fpu_rd_n;
            if (anyLow) begin
                checkOutput("strobe_pair", 72'({fpu_cs_n, fpu_wr_n, fpu_rd_n} == 3'b001 ||
                                                {fpu_cs_n, fpu_wr_n, fpu_rd_n} == 3'b010), 72'(1));
                checkOutput("strobe_recovery", 72'(prevStrobe), 72'(0));
            end
            prevStrobe = anyLow;

            if (req_accept != 2'b00) begin
                acceptCount++;
                if (acceptQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL accept_unexpected: got %b, expected none", req_accept);
                end else begin
                    expId = acceptQ.pop_front();
                    checkOutput("accept_id", 72'(req_accept), 72'(2'b01 << expId));
                end
                wrAddrs = '0; wrBytes = '0; rdAddrs = '0;
                nWrites = 0; nReads = 0; waitPhase = 0; waitCnt = 0; ackCnt = 0;
            end

            if (!fpu_cs_n && !fpu_wr_n) begin
                if (nWrites < 9) begin
                    wrAddrs[nWrites * 4 +: 4] = fpu_addr;
                    wrBytes[nWrites * 8 +: 8] = fpu_wdata;
                end
                nWrites++;
                if (fpu_addr == 4'd8) begin
                    waitPhase = 1;
                    waitCnt   = 0;
                end
            end else if (waitPhase == 1) begin
                waitPhase = 2;
            end else if (waitPhase == 2) begin
                if (!fpu_cs_n || fpu_end_ack) waitPhase = 3;
                else waitCnt++;
            end

            if (!fpu_cs_n && !fpu_rd_n) begin
                if (nReads < 4) rdAddrs[nReads * 4 +: 4] = fpu_addr;
                nReads++;
            end

            if (fpu_end_ack) ackCnt++;

            if (rsp_valid != 2'b00) begin
                if (rspQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rsp_unexpected: got %b, expected none", rsp_valid);
                end else begin
                    e = rspQ.pop_front();
                    checkOutput("rsp_id", 72'(rsp_valid), 72'(2'b01 << e.id));
                    checkOutput("rsp_result", 72'(rsp_result), 72'(e.result));
                    checkOutput("rsp_err", 72'(rsp_err), 72'(e.err));
                    checkOutput("wr_count", 72'(nWrites), 72'(9));
                    checkOutput("wr_addrs", 72'(wrAddrs), 72'(36'h876543210));
                    checkOutput("wr_bytes", wrBytes, {4'h0, e.op, e.b, e.a});
                    checkOutput("rd_count", 72'(nReads), 72'(e.nReads));
                    if (e.nReads == 4) checkOutput("rd_addrs", 72'(rdAddrs), 72'(16'hCBA9));
                    checkOutput("wait_cycles", 72'(waitCnt), 72'(e.waitLen));
                    checkOutput("ack_cycles", 72'(ackCnt), 72'(e.ackLen));
                    checkOutput("ack_to_rsp", 72'({prevEndAck, fpu_end_ack}), 72'(2'b10));
                end
            end
            prevEndAck = fpu_end_ack;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        arst_n    = 1'b0;
        req_valid = 2'b00;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_busy", 72'(busy), 72'(0));
        checkOutput("rst_strobes", 72'({fpu_cs_n, fpu_wr_n, fpu_rd_n}), 72'(3'b111));
        checkOutput("rst_end_ack", 72'(fpu_end_ack), 72'(0));
        checkOutput("rst_addr", 72'(fpu_addr), 72'(0));
        checkOutput("rst_wdata", 72'(fpu_wdata), 72'(0));
        checkOutput("rst_accept", 72'(req_accept), 72'(0));
        checkOutput("rst_rsp_valid", 72'(rsp_valid), 72'(0));
        checkOutput("rst_rsp_result", 72'(rsp_result), 72'(0));
        checkOutput("rst_rsp_err", 72'(rsp_err), 72'(0));
        arst_n = 1'b1;
        @(negedge clk);

        // Single add from requester 0; cmd_end 5 cycles after the opcode
        // write gives 4 WAIT_END cycles.
        $display("[TB] single add");
        req0_a = V0_A; req0_b = V0_B; req0_op = OP_ADD;
        acceptQ.push_back(0);
        expectResponse(0, V0_A, V0_B, OP_ADD, V0_R, 1'b0, 4, 1, 4);
        applyStimulus(2'b01, 1);
        waitDone();

        // Both requesting persistently: rr is 0, so 1,0,1,0.
        $display("[TB] simultaneous requests");
        req1_a = V1_A; req1_b = V1_B; req1_op = OP_MUL;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                acceptQ.push_back(1);
                expectResponse(1, V1_A, V1_B, OP_MUL, V1_R, 1'b0, 4, 1, 4);
            end else begin
                acceptQ.push_back(0);
                expectResponse(0, V0_A, V0_B, OP_ADD, V0_R, 1'b0, 4, 1, 4);
            end
        end
        applyStimulus(2'b11, 4);
        waitDone();

        // Sticky cmd_end: the FPU keeps cmd_end for 3 end_ack cycles.
        $display("[TB] sticky cmd_end");
        ackHold = 3;
        req1_a = V2_A; req1_b = V2_B; req1_op = OP_SUB;
        acceptQ.push_back(1);
        expectResponse(1, V2_A, V2_B, OP_SUB, V2_R, 1'b0, 4, 3, 4);
        applyStimulus(2'b10, 1);
        waitDone();
        ackHold = 1;

        // Timeout: cmd_end never arrives; 64 wait cycles, no reads.
        $display("[TB] timeout");
        endDelay = 0;
        req0_a = V2_A; req0_b = V2_B; req0_op = OP_SUB;
        acceptQ.push_back(0);
        expectResponse(0, V2_A, V2_B, OP_SUB, 32'h0, 1'b1, TIMEOUT, 1, 0);
        applyStimulus(2'b01, 1);
        waitDone();

        // Reset while waiting for cmd_end: no response may appear.
        $display("[TB] reset mid-operation");
        req1_a = V1_A; req1_b = V1_B; req1_op = OP_MUL;
        acceptQ.push_back(1);
        applyStimulus(2'b10, 1);
        repeat (25) @(negedge clk);
        checkOutput("busy_before_reset", 72'(busy), 72'(1));
        arst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 72'(busy), 72'(0));
        checkOutput("midrst_strobes", 72'({fpu_cs_n, fpu_wr_n, fpu_rd_n}), 72'(3'b111));
        checkOutput("midrst_end_ack", 72'(fpu_end_ack), 72'(0));
        checkOutput("midrst_rsp_valid", 72'(rsp_valid), 72'(0));
        checkOutput("midrst_addr", 72'(fpu_addr), 72'(0));
        arst_n = 1'b1;
        endDelay = 5;
        repeat (3) @(negedge clk);

        // After reset rr is 0 again, so a tie goes to requester 1.
        $display("[TB] request after reset");
        req0_a = V0_A; req0_b = V0_B; req0_op = OP_ADD;
        acceptQ.push_back(1);
        expectResponse(1, V1_A, V1_B, OP_MUL, V1_R, 1'b0, 4, 1, 4);
        applyStimulus(2'b11, 1);
        waitDone();

        repeat (5) @(negedge clk);
        checkOutput("queues_empty", 72'(rspQ.size() + acceptQ.size()), 72'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
